// File: rtl/line_buffer_ring.sv
// line_buffer_ring: N-deep ring of line stores with per-line replay,
// line markers, fill level and synchronous flush for the zoom path.
module line_buffer_ring #(
  parameter int NUM_BUFS    = 3,
  parameter int LINE_DEPTH  = 640,
  parameter int PIXEL_WIDTH = 8,
  parameter int MAX_REP     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [$clog2(LINE_DEPTH+1)-1:0]   cfg_line_len,
  input  logic [$clog2(MAX_REP+1)-1:0]      cfg_rep,
  input  logic                              flush,
  input  logic [PIXEL_WIDTH-1:0]            pixel_in,
  input  logic                              valid_in,
  output logic                              ready_out,
  output logic [PIXEL_WIDTH-1:0]            data_out,
  output logic                              valid_out,
  input  logic                              ready_in,
  output logic                              sol_out,
  output logic                              eol_out,
  output logic                              last_rep_out,
  output logic [$clog2(NUM_BUFS+1)-1:0]     fill_level
);

  localparam int LW = $clog2(LINE_DEPTH + 1);
  localparam int RW = $clog2(MAX_REP + 1);
  localparam int FW = $clog2(NUM_BUFS + 1);
  localparam int BW = $clog2(NUM_BUFS);
  localparam int PW = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;

  localparam logic [LW-1:0] DEPTH_L = LW'(LINE_DEPTH);
  localparam logic [RW-1:0] MAXR_L  = RW'(MAX_REP);
  localparam logic [BW-1:0] LAST_B  = BW'(NUM_BUFS - 1);

  logic [PIXEL_WIDTH-1:0] mem [NUM_BUFS][LINE_DEPTH];

  logic [LW-1:0]       wr_ptr;
  logic [LW-1:0]       rd_ptr;
  logic [BW-1:0]       wr_buf;
  logic [BW-1:0]       rd_buf;
  logic [RW-1:0]       rep_cnt;
  logic [NUM_BUFS-1:0] full;
  logic [NUM_BUFS-1:0] full_nxt;
  logic [LW-1:0]       len_q;
  logic [RW-1:0]       rep_q;

  logic [LW-1:0] len_cfg;
  logic [RW-1:0] rep_cfg;
  logic [LW-1:0] len_m1;
  logic [RW-1:0] rep_m1;
  logic          wr_fire;
  logic          rd_fire;
  logic          wr_last;
  logic          rd_last;
  logic          rep_last;
  logic          idle;

  function automatic logic [BW-1:0] adv(input logic [BW-1:0] b);
    return (b == LAST_B) ? '0 : b + 1'b1;
  endfunction

  // Saturate raw config and derive handshake/pointer conditions.
  always_comb begin
    len_cfg = cfg_line_len;
    if (cfg_line_len == '0 || cfg_line_len > DEPTH_L)
      len_cfg = DEPTH_L;
    rep_cfg = cfg_rep;
    if (cfg_rep == '0)
      rep_cfg = RW'(1);
    else if (cfg_rep > MAXR_L)
      rep_cfg = MAXR_L;
    len_m1   = len_q - LW'(1);
    rep_m1   = rep_q - RW'(1);
    wr_fire  = valid_in && ready_out && !flush;
    rd_fire  = valid_out && ready_in && !flush;
    wr_last  = (wr_ptr == len_m1);
    rd_last  = (rd_ptr == len_m1);
    rep_last = (rep_cnt == rep_m1);
    idle     = (full == '0) && (wr_ptr == '0) &&
               (rd_ptr == '0) && (rep_cnt == '0);
  end

  // Writer completes a buffer while reader releases a different one.
  always_comb begin
    full_nxt = full;
    if (wr_fire && wr_last)
      full_nxt[wr_buf] = 1'b1;
    if (rd_fire && rd_last && rep_last)
      full_nxt[rd_buf] = 1'b0;
  end

  // Count of full buffers.
  always_comb begin
    fill_level = '0;
    for (int i = 0; i < NUM_BUFS; i++)
      fill_level = fill_level + FW'(full[i]);
  end

  assign ready_out    = !full[wr_buf];
  assign valid_out    = full[rd_buf];
  assign data_out     = mem[rd_buf][rd_ptr[PW-1:0]];
  assign sol_out      = (rd_ptr == '0);
  assign eol_out      = rd_last;
  assign last_rep_out = rep_last;

  // Line storage; never cleared, flush only drops the bookkeeping.
  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_buf][wr_ptr[PW-1:0]] <= pixel_in;
  end

  // Config shadow registers, only track inputs while fully idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= DEPTH_L;
      rep_q <= RW'(1);
    end else if (idle) begin
      len_q <= len_cfg;
      rep_q <= rep_cfg;
    end
  end

  // Full flags per buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      full <= '0;
    else if (flush)
      full <= '0;
    else
      full <= full_nxt;
  end

  // Write pointer and write buffer index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      wr_buf <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      wr_buf <= '0;
    end else if (wr_fire) begin
      if (wr_last) begin
        wr_ptr <= '0;
        wr_buf <= adv(wr_buf);
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Read pointer, replay counter and read buffer index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      rd_buf  <= '0;
      rep_cnt <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      rd_buf  <= '0;
      rep_cnt <= '0;
    end else if (rd_fire) begin
      if (rd_last) begin
        rd_ptr <= '0;
        if (rep_last) begin
          rep_cnt <= '0;
          rd_buf  <= adv(rd_buf);
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end else begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_ring.sv
// tb_line_buffer_ring: directed steps with a queue scoreboard
// for line_buffer_ring (3 buffers, depth 4, rep up to 8).
module tb_line_buffer_ring;

  logic       clk;
  logic       rst;
  logic [2:0] cfg_line_len;
  logic [3:0] cfg_rep;
  logic       flush;
  logic [7:0] pixel_in;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ready_in;
  logic       sol_out;
  logic       eol_out;
  logic       last_rep_out;
  logic [1:0] fill_level;

  line_buffer_ring #(
    .NUM_BUFS(3), .LINE_DEPTH(4),
    .PIXEL_WIDTH(8), .MAX_REP(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_line_len(cfg_line_len), .cfg_rep(cfg_rep),
    .flush(flush),
    .pixel_in(pixel_in), .valid_in(valid_in),
    .ready_out(ready_out),
    .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in),
    .sol_out(sol_out), .eol_out(eol_out),
    .last_rep_out(last_rep_out),
    .fill_level(fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  bit wen = 0;
  bit rdy = 0;
  bit mid_line = 0;
  bit fill_chk = 0;
  logic [7:0]  wq [$];
  logic [10:0] exq [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic add_seq(input int start, input int len,
                         input int rep, input bit expect_it);
    for (int k = 0; k < len; k++)
      wq.push_back(8'(start + k));
    if (expect_it)
      for (int r = 0; r < rep; r++)
        for (int k = 0; k < len; k++)
          exq.push_back({8'(start + k), k == 0,
                         k == len - 1, r == rep - 1});
  endtask

  task automatic cyc();
    logic [10:0] got;
    logic [10:0] want;
    valid_in = wen && (wq.size() > 0);
    pixel_in = (wq.size() > 0) ? wq[0] : 8'h00;
    ready_in = rdy;
    @(negedge clk);
    if (valid_out && ready_in) begin
      got  = {data_out, sol_out, eol_out, last_rep_out};
      want = (exq.size() > 0) ? exq.pop_front() : 'x;
      checks++;
      assert (got === want) else begin
        errors++;
        $error("FAIL out_pixel got %0h want %0h", got, want);
      end
      if (fill_chk) chk("fill_during_rep", 32'(fill_level), 1);
      pops++;
      mid_line = !eol_out;
    end else if (mid_line) begin
      chk("valid_mid_line", 32'(valid_out), 1);
    end
    if (valid_in && ready_out) void'(wq.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exq.size() == 0 && wq.size() == 0) break;
      cyc();
    end
    chk("drain_done", 32'(exq.size() + wq.size()), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cfg_line_len = 3'd4;
    cfg_rep = 4'd1;
    flush = 1'b0;
    pixel_in = '0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk("rst_ready", 32'(ready_out), 1);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_fill", 32'(fill_level), 0);
    chk("rst_sol", 32'(sol_out), 1);
    chk("rst_eol", 32'(eol_out), 0);
    chk("rst_last", 32'(last_rep_out), 1);

    // three lines into the ring with reader stalled
    add_seq(1, 4, 1, 1);
    add_seq(5, 4, 1, 1);
    add_seq(9, 4, 1, 1);
    wen = 1;
    rdy = 0;
    repeat (12) cyc();
    chk("t1_fill_full", 32'(fill_level), 3);
    chk("t1_ready_low", 32'(ready_out), 0);
    chk("t1_valid", 32'(valid_out), 1);
    rdy = 1;
    drain(100);
    chk("t1_fill_empty", 32'(fill_level), 0);
    chk("t1_ready_back", 32'(ready_out), 1);

    // replicate one line three times
    cfg_rep = 4'd3;
    rdy = 0;
    cyc();
    add_seq(10, 4, 3, 1);
    repeat (5) cyc();
    chk("t2_fill_one", 32'(fill_level), 1);
    fill_chk = 1;
    rdy = 1;
    drain(100);
    fill_chk = 0;
    chk("t2_fill_zero", 32'(fill_level), 0);

    // short lines of length 2
    cfg_rep = 4'd1;
    cfg_line_len = 3'd2;
    rdy = 0;
    cyc();
    add_seq(7, 2, 1, 1);
    add_seq(9, 2, 1, 1);
    repeat (5) cyc();
    chk("t3_fill_two", 32'(fill_level), 2);
    chk("t3_ready", 32'(ready_out), 1);
    chk("t3_wr_ptr", 32'(dut.wr_ptr), 0);
    rdy = 1;
    drain(100);

    // continuous streaming, 20 lines
    cfg_line_len = 3'd4;
    rdy = 0;
    cyc();
    for (int l = 0; l < 20; l++)
      add_seq(3 + 4 * l, 4, 1, 1);
    pops = 0;
    rdy = 1;
    drain(300);
    chk("t4_pops", 32'(pops), 80);

    // flush with two full lines, a partial and a live write
    rdy = 0;
    add_seq(8'h40, 10, 1, 0);
    repeat (10) cyc();
    chk("t5_fill_two", 32'(fill_level), 2);
    chk("t5_wr_ptr", 32'(dut.wr_ptr), 2);
    valid_in = 1'b1;
    pixel_in = 8'h55;
    ready_in = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    wq.delete();
    mid_line = 0;
    chk("t5_fill_zero", 32'(fill_level), 0);
    chk("t5_ready", 32'(ready_out), 1);
    chk("t5_valid", 32'(valid_out), 0);
    chk("t5_wr_buf", 32'(dut.wr_buf), 0);
    add_seq(8'h61, 4, 1, 1);
    repeat (4) cyc();
    chk("t5_rd_buf", 32'(dut.rd_buf), 0);
    chk("t5_valid_line", 32'(valid_out), 1);
    rdy = 1;
    drain(100);

    // reset in the middle of a replay pass
    cfg_rep = 4'd3;
    rdy = 0;
    cyc();
    add_seq(8'h80, 4, 3, 1);
    repeat (4) cyc();
    pops = 0;
    rdy = 1;
    for (int i = 0; i < 30; i++) begin
      if (pops == 6) break;
      cyc();
    end
    chk("t6_pops", 32'(pops), 6);
    chk("t6_rep_cnt", 32'(dut.rep_cnt), 1);
    rdy = 0;
    ready_in = 1'b0;
    valid_in = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(ready_out), 1);
    chk("t6_rst_valid", 32'(valid_out), 0);
    chk("t6_rst_fill", 32'(fill_level), 0);
    chk("t6_rst_sol", 32'(sol_out), 1);
    chk("t6_rst_eol", 32'(eol_out), 0);
    chk("t6_rst_last", 32'(last_rep_out), 1);
    exq.delete();
    wq.delete();
    mid_line = 0;
    cfg_line_len = 3'd3;
    cfg_rep = 4'd2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    chk("t6_rep_loaded", 32'(last_rep_out), 0);
    add_seq(8'h91, 3, 2, 1);
    rdy = 1;
    drain(100);
    chk("t6_fill_end", 32'(fill_level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
